// File: rtl/beacon_tx.sv
// ============================================================================
// beacon_tx : gated square-wave tone-burst generator for the acoustic beacon.
// Optional macro BEACON_TX_JITTER_EN adds LFSR-based gap jitter.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module beacon_tx #(
  parameter int CARRIER_HALF = 2500,
  parameter int BURST_LEN    = 1000000,
  parameter int GAP_LEN      = 1000000,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  output logic        beacon_out,
  output logic        envelope,
  output logic        busy,
  output logic        done,
  output logic [15:0] burst_count
);

  localparam int CAR_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CNT_W-1:0] C_BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CAR_W-1:0] C_CAR_LAST   = CAR_W'(CARRIER_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CAR_W-1:0]  car_cnt_q, car_cnt_d;
  logic              carrier_q, carrier_d;
  logic [15:0]       burst_count_q, burst_count_d;
  logic              beacon_out_q, beacon_out_d;
  logic              envelope_q, envelope_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              w_launch;
  logic [CNT_W-1:0]  w_gap_last;

`ifdef BEACON_TX_JITTER_EN
  logic [7:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  gap_last_q, gap_last_d;
  assign w_gap_last = gap_last_q;
`else
  assign w_gap_last = C_GAP_LAST;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    car_cnt_d     = car_cnt_q;
    carrier_d     = carrier_q;
    burst_count_d = burst_count_q;
    done_d        = 1'b0;
    w_launch      = 1'b0;
`ifdef BEACON_TX_JITTER_EN
    lfsr_d        = lfsr_q;
    gap_last_d    = gap_last_q;
`endif
    case (state_q)
      S_IDLE: begin
        w_launch = start | enable;
      end
      S_ON: begin
        if (cnt_q == C_BURST_LAST) begin
          state_d       = S_OFF;
          cnt_d         = '0;
          car_cnt_d     = '0;
          carrier_d     = 1'b0;
          burst_count_d = burst_count_q + 16'd1;
`ifdef BEACON_TX_JITTER_EN
          // The freshly stepped LFSR value stretches the gap that starts now.
          lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          gap_last_d = C_GAP_LAST + CNT_W'(lfsr_d);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (car_cnt_q == C_CAR_LAST) begin
            car_cnt_d = '0;
            carrier_d = ~carrier_q;
          end else begin
            car_cnt_d = car_cnt_q + 1'b1;
          end
        end
      end
      S_OFF: begin
        if (cnt_q == w_gap_last) begin
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
          w_launch = enable;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A launch always starts a fresh burst with the carrier high.
    if (w_launch) begin
      state_d   = S_ON;
      cnt_d     = '0;
      car_cnt_d = '0;
      carrier_d = 1'b1;
    end

    envelope_d   = (state_d == S_ON);
    beacon_out_d = (state_d == S_ON) & carrier_d;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      car_cnt_q     <= '0;
      carrier_q     <= 1'b0;
      burst_count_q <= '0;
      beacon_out_q  <= 1'b0;
      envelope_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      car_cnt_q     <= car_cnt_d;
      carrier_q     <= carrier_d;
      burst_count_q <= burst_count_d;
      beacon_out_q  <= beacon_out_d;
      envelope_q    <= envelope_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef BEACON_TX_JITTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q     <= 8'hA5;
      gap_last_q <= C_GAP_LAST;
    end else begin
      lfsr_q     <= lfsr_d;
      gap_last_q <= gap_last_d;
    end
  end
`endif

  assign beacon_out  = beacon_out_q;
  assign envelope    = envelope_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign burst_count = burst_count_q;

endmodule

`default_nettype wire
